axi_boundary_write_arbiter: RTL and testbench
=============================================

Name: axi_boundary_write_arbiter

Overview:
- Shares one AXI boundary write port (`m_*` side, feeding the boundary-write stage) between N_REQ requesters.
- Round-robin arbitration at burst granularity: once granted, a requester owns the port for exactly len+1 data beats.
- Granted requester's beats are forwarded combinationally; address and length are captured at grant and held stable for the whole burst.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- s_valid  input  N_REQ  per-requester beat valid.
- s_ready  output  N_REQ  per-requester beat accept.
- s_addr  input  N_REQ*ADDR_W  burst start address; requester i at [i*ADDR_W +: ADDR_W].
- s_wdata  input  N_REQ*DATA_W  beat data.
- s_wstrb  input  N_REQ*DATA_W/8  beat strobes.
- s_len  input  N_REQ*8  burst length minus 1.
- m_valid  output  1  beat valid to boundary stage.
- m_ready  input  1  beat accept from boundary stage.
- m_addr  output  ADDR_W  latched burst address.
- m_wdata  output  DATA_W  forwarded data.
- m_wstrb  output  DATA_W/8  forwarded strobes.
- m_len  output  8  latched burst length.
- busy  output  1  a burst is granted.
- grant_idx  output  3  index of the granted requester; 0 when idle.

Behaviour:
- Reset values:
  - s_valid/data interpretation: nothing is accepted during or right after reset.
  - s_ready = 0, m_valid = 0, m_addr = 0, m_len = 0, busy = 0, grant_idx = 0.
  - Round-robin pointer = 0, beat counter = 0, state = IDLE.
- Requester contract: s_addr and s_len must be valid with the first s_valid of a burst and stay stable until the burst's last beat is accepted.
- State IDLE:
  - s_ready = 0, m_valid = 0.
  - If any s_valid is high, select the first requester with valid high, searching from the pointer upward and wrapping modulo N_REQ.
  - Next edge: capture that requester's s_addr and s_len into m_addr and m_len, set grant_idx, clear the beat counter, go to GRANT, busy = 1.
  - Grant latency: one cycle from s_valid to m_valid. m_wdata/m_wstrb are don't-care while idle; drive 0.
- State GRANT:
  - m_valid = s_valid[g]; s_ready[g] = m_ready; s_ready of every other requester = 0.
  - m_wdata and m_wstrb are muxed from requester g.
  - Each beat where m_valid & m_ready is high increments the beat counter (8-bit).
  - On a handshake with counter == m_len (last beat): next edge goes to IDLE, busy = 0, pointer = (g+1) mod N_REQ; m_addr and m_len keep their last values.
  - Back-to-back bursts: the next grant needs the IDLE cycle, so there is one bubble minimum between bursts.
- Boundary conditions:
  - len = 0: single beat; release after the first handshake.
  - len = 255: 256 beats; counter compares equal at 255 and must not wrap before release.
  - Requester deasserts s_valid mid-burst: m_valid drops and the grant is held indefinitely (no timeout, no preemption).
  - m_ready held low: beats stall and the counter does not advance.
  - Other requesters asserting valid mid-burst: ignored until release.
  - Simultaneous requests at IDLE: round-robin from the pointer. With pointer = 1 and requesters 0 and 1 both valid, grant goes to 1.
  - Only the granted requester is ever shown s_ready high; at most one s_ready bit is high in any cycle.
  - Reset asserted mid-burst: all outputs go to reset values immediately (asynchronous); the partial burst is abandoned and the downstream side sees m_valid fall without completion.
  - This block performs no 4 KB splitting; the downstream boundary stage owns that.

Test Plan:
- Single requester 0, addr 0x1000, len 3, m_ready = 1 -> m_valid rises 1 cycle after s_valid; 4 handshakes with m_addr = 0x1000, m_len = 3; busy falls after the 4th; pointer = 1.
- Requesters 0 and 1 both valid from reset, len 1 each -> burst 0 (2 beats), one idle cycle, burst 1 (2 beats); s_ready[1] = 0 throughout burst 0.
- len 0 on requester 1 while requester 0 holds len 7 with pointer = 1 -> requester 1 served in one beat, then requester 0 runs 8 beats.
- Burst len 255 with m_ready toggling every other cycle -> exactly 256 handshakes, release only after the last; no early wrap.
- Granted requester drops s_valid for 5 cycles mid-burst while another requester is valid -> m_valid = 0 for those cycles, grant unchanged, burst completes with the correct beat count.
- rst pulsed after beat 2 of a len-5 burst -> m_valid, s_ready and busy go to 0 at once; after release, a new request is granted from pointer 0.

Source files
------------

// File: rtl/axi_boundary_write_arbiter.sv
// Round-robin arbiter sharing one AXI boundary write port between N_REQ requesters.
// Arbitration is per burst: a granted requester owns the port for len+1 beats.
module axi_boundary_write_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             s_valid,
    output logic [N_REQ-1:0]             s_ready,
    input  logic [N_REQ*ADDR_W-1:0]      s_addr,
    input  logic [N_REQ*DATA_W-1:0]      s_wdata,
    input  logic [N_REQ*(DATA_W/8)-1:0]  s_wstrb,
    input  logic [N_REQ*8-1:0]           s_len,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [ADDR_W-1:0]            m_addr,
    output logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W/8-1:0]          m_wstrb,
    output logic [7:0]                   m_len,
    output logic                         busy,
    output logic [2:0]                   grant_idx
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          rr_ptr;
    logic [2:0]          ptr_after;
    logic [7:0]          beat_cnt;
    logic [7:0]          valid_pad;
    logic [3:0]          cand;
    logic [2:0]          pick_idx;
    logic                pick_found;
    logic [ADDR_W-1:0]   pick_addr;
    logic [7:0]          pick_len;
    logic                handshake;
    logic                last_beat;
    logic                load_grant;

    assign valid_pad = 8'(s_valid);
    assign ptr_after = (({1'b0, grant_idx} + 4'd1) >= 4'(N_REQ)) ? 3'd0 : grant_idx + 3'd1;

    // Search upward from the round-robin pointer, wrapping modulo N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!pick_found && valid_pad[cand[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == 3'(i)) begin
                pick_addr = s_addr[i*ADDR_W +: ADDR_W];
                pick_len  = s_len[i*8 +: 8];
            end
            if (state == GRANT && grant_idx == 3'(i)) begin
                m_wdata = s_wdata[i*DATA_W +: DATA_W];
                m_wstrb = s_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        load_grant = 1'b0;
        busy       = (state == GRANT);
        m_valid    = (state == GRANT) && valid_pad[grant_idx];
        handshake  = m_valid && m_ready;
        last_beat  = handshake && (beat_cnt == m_len);
        s_ready    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_ready[i] = (state == GRANT) && (grant_idx == 3'(i)) && m_ready;
        end
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt  = GRANT;
                    load_grant = 1'b1;
                end
            end
            GRANT: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // m_addr and m_len deliberately keep their values after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            beat_cnt  <= '0;
            m_addr    <= '0;
            m_len     <= '0;
        end else if (load_grant) begin
            grant_idx <= pick_idx;
            m_addr    <= pick_addr;
            m_len     <= pick_len;
            beat_cnt  <= '0;
        end else if (last_beat) begin
            grant_idx <= '0;
            rr_ptr    <= ptr_after;
        end else if (handshake) begin
            beat_cnt  <= beat_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_boundary_write_arbiter.sv
// Bench for axi_boundary_write_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a burst-level reference model.
module tb_axi_boundary_write_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N_REQ-1:0]           s_valid;
    logic [N_REQ-1:0]           s_ready;
    logic [N_REQ*ADDR_W-1:0]    s_addr;
    logic [N_REQ*DATA_W-1:0]    s_wdata;
    logic [N_REQ*STRB_W-1:0]    s_wstrb;
    logic [N_REQ*8-1:0]         s_len;
    logic                       m_valid;
    logic                       m_ready;
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic [STRB_W-1:0]          m_wstrb;
    logic [7:0]                 m_len;
    logic                       busy;
    logic [2:0]                 grant_idx;

    axi_boundary_write_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_len(s_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_len(m_len), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    // Requester agents
    logic [ADDR_W-1:0] req_addr [N_REQ];
    logic [7:0]        req_len  [N_REQ];
    logic [DATA_W-1:0] req_data [N_REQ];
    logic [STRB_W-1:0] req_strb [N_REQ];
    bit                req_active [N_REQ];
    int                req_left [N_REQ];
    int                req_hold [N_REQ];
    int                ready_mode;
    bit                random_start;

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        s_len   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_addr[i*ADDR_W +: ADDR_W]  = req_addr[i];
            s_wdata[i*DATA_W +: DATA_W] = req_data[i];
            s_wstrb[i*STRB_W +: STRB_W] = req_strb[i];
            s_len[i*8 +: 8]             = req_len[i];
        end
    end

    // Reference model: burst owner, beats still owed, rotation pointer
    bit                mdl_busy;
    int                mdl_owner;
    int                mdl_left;
    int                mdl_ptr;
    logic [ADDR_W-1:0] mdl_addr;
    logic [7:0]        mdl_len;

    int n_cmp;
    int n_err;
    int cyc;
    int dut_hs;
    int burst_beats;
    bit prev_busy;
    int grant_log[$];
    int beat_log[$];
    int rise_log[$];
    int fall_log[$];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int gAt(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic int bAt(input int i);
        return (i < beat_log.size()) ? beat_log[i] : -1;
    endfunction

    function automatic bit anyActive();
        bit a = 1'b0;
        for (int i = 0; i < N_REQ; i++) a |= req_active[i];
        return a;
    endfunction

    task automatic clearLogs();
        grant_log.delete();
        beat_log.delete();
        rise_log.delete();
        fall_log.delete();
        dut_hs = 0;
    endtask

    task automatic startBurst(input int i, input logic [ADDR_W-1:0] a, input logic [7:0] l);
        req_addr[i]   = a;
        req_len[i]    = l;
        req_left[i]   = int'(l) + 1;
        req_active[i] = 1'b1;
        req_hold[i]   = 0;
        req_data[i]   = $urandom;
        req_strb[i]   = STRB_W'($urandom);
        s_valid[i]    = 1'b1;
    endtask

    task automatic applyStimulus();
        case (ready_mode)
            1:       m_ready = ~m_ready;
            2:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b1;
        endcase
        for (int i = 0; i < N_REQ; i++) begin
            if (req_active[i] && req_left[i] == 0) req_active[i] = 1'b0;
            if (random_start && !req_active[i] && $urandom_range(0, 3) == 0) begin
                startBurst(i, $urandom,
                           ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7)));
            end
            if (random_start && req_active[i] && req_hold[i] == 0 && $urandom_range(0, 15) == 0) begin
                req_hold[i] = $urandom_range(1, 4);
            end
            s_valid[i] = req_active[i] && (req_hold[i] == 0);
            if (req_hold[i] > 0) req_hold[i]--;
            req_data[i] = $urandom;
            req_strb[i] = STRB_W'($urandom);
        end
    endtask

    // One clock: check outputs at negedge, advance model, drive new inputs after posedge
    task automatic runCycle();
        logic [N_REQ-1:0] exp_ready;
        logic             exp_mvalid;
        bit               found;
        int               c;
        @(negedge clk);
        cyc++;
        exp_ready  = '0;
        exp_mvalid = 1'b0;
        if (!rst && mdl_busy) begin
            exp_mvalid = s_valid[mdl_owner];
            if (m_ready) exp_ready[mdl_owner] = 1'b1;
        end
        checkOutput("m_valid",   m_valid,   exp_mvalid);
        checkOutput("s_ready",   s_ready,   exp_ready);
        checkOutput("busy",      busy,      mdl_busy);
        checkOutput("grant_idx", grant_idx, mdl_busy ? mdl_owner : 0);
        checkOutput("m_addr",    m_addr,    mdl_addr);
        checkOutput("m_len",     m_len,     mdl_len);
        checkOutput("m_wdata",   m_wdata,   mdl_busy ? req_data[mdl_owner] : '0);
        checkOutput("m_wstrb",   m_wstrb,   mdl_busy ? req_strb[mdl_owner] : '0);

        if (!busy && prev_busy) begin
            beat_log.push_back(burst_beats);
            fall_log.push_back(cyc);
        end
        if (busy && !prev_busy) begin
            grant_log.push_back(int'(grant_idx));
            rise_log.push_back(cyc);
            burst_beats = 0;
        end
        if (m_valid && m_ready) begin
            dut_hs++;
            burst_beats++;
        end
        prev_busy = busy;

        if (!rst) begin
            if (mdl_busy) begin
                if (exp_mvalid && m_ready) begin
                    mdl_left--;
                    if (mdl_left == 0) begin
                        mdl_busy = 1'b0;
                        mdl_ptr  = (mdl_owner + 1) % N_REQ;
                    end
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < N_REQ; k++) begin
                    c = (mdl_ptr + k) % N_REQ;
                    if (!found && s_valid[c]) begin
                        found     = 1'b1;
                        mdl_busy  = 1'b1;
                        mdl_owner = c;
                        mdl_addr  = req_addr[c];
                        mdl_len   = req_len[c];
                        mdl_left  = int'(req_len[c]) + 1;
                    end
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_ready[i] && s_valid[i]) req_left[i]--;
        end
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    task automatic runUntilIdle(input int max_cycles);
        int n = 0;
        while ((anyActive() || mdl_busy) && n < max_cycles) begin
            runCycle();
            n++;
        end
        if (n >= max_cycles) checkOutput("idle_timeout", 1, 0);
        runCycle();
        runCycle();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            req_active[i] = 1'b0;
            req_left[i]   = 0;
            req_hold[i]   = 0;
            s_valid[i]    = 1'b0;
        end
        mdl_busy  = 1'b0;
        mdl_owner = 0;
        mdl_left  = 0;
        mdl_ptr   = 0;
        mdl_addr  = '0;
        mdl_len   = '0;
        m_ready   = 1'b1;
        runCycle();
        runCycle();
        rst = 1'b0;
        clearLogs();
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        s_valid      = '0;
        m_ready      = 1'b1;
        ready_mode   = 0;
        random_start = 1'b0;
        n_cmp = 0; n_err = 0; cyc = 0; burst_beats = 0; prev_busy = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i] = '0; req_len[i] = '0; req_data[i] = '0; req_strb[i] = '0;
        end
        applyReset();

        // Single requester, 4-beat burst; pointer moves to 1
        startBurst(0, 32'h1000, 8'd3);
        runUntilIdle(50);
        checkOutput("t1_grant", gAt(0), 0);
        checkOutput("t1_beats", bAt(0), 4);
        checkOutput("t1_addr_held", m_addr, 32'h1000);
        checkOutput("t1_len_held", m_len, 3);

        // Pointer = 1: len-0 requester 1 first, then requester 0 for 8 beats
        startBurst(0, 32'h2000, 8'd7);
        startBurst(1, 32'h3000, 8'd0);
        runUntilIdle(100);
        checkOutput("t3_grant_a", gAt(1), 1);
        checkOutput("t3_beats_a", bAt(1), 1);
        checkOutput("t3_grant_b", gAt(2), 0);
        checkOutput("t3_beats_b", bAt(2), 8);

        // Two simultaneous requesters from reset, one bubble between bursts
        applyReset();
        startBurst(0, 32'h4000, 8'd1);
        startBurst(1, 32'h5000, 8'd1);
        runUntilIdle(100);
        checkOutput("t2_grant_a", gAt(0), 0);
        checkOutput("t2_grant_b", gAt(1), 1);
        checkOutput("t2_beats_a", bAt(0), 2);
        checkOutput("t2_beats_b", bAt(1), 2);
        checkOutput("t2_bubble", (rise_log.size() > 1 && fall_log.size() > 0) ? rise_log[1] - fall_log[0] : -1, 1);

        // 256-beat burst with m_ready toggling
        clearLogs();
        ready_mode = 1;
        startBurst(2, 32'h6000, 8'd255);
        runUntilIdle(1000);
        ready_mode = 0;
        m_ready    = 1'b1;
        checkOutput("t4_grant", gAt(0), 2);
        checkOutput("t4_handshakes", dut_hs, 256);
        checkOutput("t4_beats", bAt(0), 256);

        // Granted requester pauses 5 cycles while another waits
        applyReset();
        startBurst(0, 32'h7000, 8'd7);
        startBurst(1, 32'h8000, 8'd2);
        runCycle(); runCycle(); runCycle();
        req_hold[0] = 5;
        runUntilIdle(100);
        checkOutput("t5_grant_a", gAt(0), 0);
        checkOutput("t5_beats_a", bAt(0), 8);
        checkOutput("t5_grant_b", gAt(1), 1);
        checkOutput("t5_beats_b", bAt(1), 3);

        // Asynchronous reset in the middle of a burst; pointer returns to 0
        applyReset();
        startBurst(1, 32'h9000, 8'd0);
        runUntilIdle(50);
        clearLogs();
        startBurst(0, 32'hA000, 8'd5);
        n = 0;
        while (dut_hs < 2 && n < 20) begin
            runCycle();
            n++;
        end
        if (n >= 20) checkOutput("t6_timeout", 1, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_m_valid", m_valid, 0);
        checkOutput("t6_s_ready", s_ready, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_grant_idx", grant_idx, 0);
        checkOutput("t6_m_addr", m_addr, 0);
        applyReset();
        startBurst(1, 32'hB000, 8'd0);
        startBurst(2, 32'hC000, 8'd0);
        runUntilIdle(50);
        checkOutput("t6_regrant_a", gAt(0), 1);
        checkOutput("t6_regrant_b", gAt(1), 2);

        // Random traffic against the model
        applyReset();
        random_start = 1'b1;
        ready_mode   = 2;
        repeat (3000) runCycle();
        random_start = 1'b0;
        runUntilIdle(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
